desplazador_secuencial: RTL and testbench



---
 rtl/desplazador_secuencial.sv | 107 ++++++++++
 tb/tb_desplazador_secuencial.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/desplazador_secuencial.sv
// Multi-cycle shift unit. It moves the operand one bit position per clock in a
// working register, then publishes the result on Y together with a one-cycle
// done pulse. Supported modes: logical right, logical left, arithmetic right
// and rotate right.
module desplazador_secuencial #(
  parameter int WIDTH = 6,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       modo,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done
);

  // One extra counter bit, because WIDTH may equal 2^AMT_W and the clamped
  // count must still be representable.
  localparam int CNT_W = AMT_W + 1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] eff_cnt;
  logic [1:0]       modo_q;

  // Effective count at the moment of capture. Non-rotate modes saturate at
  // WIDTH, because further shifts cannot change the result. Rotate keeps the
  // raw amount so that it wraps on its own.
  always_comb begin
    eff_cnt = {1'b0, amt};
    if (modo != M_ROR && {1'b0, amt} > WIDTH_C) eff_cnt = WIDTH_C;
  end

  // Single-position shift of the working register for the latched mode.
  always_comb begin
    work_nxt = work_q;
    case (modo_q)
      M_LSR:   work_nxt = {1'b0, work_q[WIDTH-1:1]};
      M_LSL:   work_nxt = {work_q[WIDTH-2:0], 1'b0};
      M_ASR:   work_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      M_ROR:   work_nxt = {work_q[0], work_q[WIDTH-1:1]};
      default: work_nxt = work_q;
    endcase
  end

  // Control FSM. busy and done are registered next to the state, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      modo_q  <= M_LSR;
      Y       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work_q  <= A;
            modo_q  <= modo;
            cnt_q   <= eff_cnt;
            state_q <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            Y       <= work_q;
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            work_q <= work_nxt;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // This state lasts exactly one cycle. start is not looked at here.
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Randomised self-checking bench for desplazador_secuencial. The reference
// model computes each result from whole-word shift arithmetic.
module tb_desplazador_secuencial;
  localparam int W  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  A = '0;
  logic [AW-1:0] amt = '0;
  logic [1:0]    modo = '0;
  logic [W-1:0]  Y;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  desplazador_secuencial #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .amt(amt),
    .modo(modo), .Y(Y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Number of shift cycles the operation takes.
  function automatic int eff_of(input int am, input logic [1:0] md);
    if (md == 2'b11) return am;
    return (am > W) ? W : am;
  endfunction

  // Reference result, computed as one whole-word operation.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int am,
                                             input logic [1:0] md);
    logic signed [W-1:0] s;
    int k;
    k = (am > W) ? W : am;
    s = a;
    case (md)
      2'b00: return a >> k;
      2'b01: return a << k;
      2'b10: return W'(s >>> k);
      default: begin
        k = am % W;
        if (k == 0) return a;
        return (a >> k) | (a << (W - k));
      end
    endcase
  endfunction

  // Run one operation and check the result, the latency, the busy window,
  // that Y holds during shifting, and the done pulse width.
  task automatic run_op(input logic [W-1:0] a, input logic [AW-1:0] am,
                        input logic [1:0] md, input bit scramble, input string nm);
    logic [W-1:0] exp_y, prev_y;
    int n, cyc, busy_cnt;
    bit got, y_moved;
    exp_y = ref_shift(a, int'(am), md);
    n = eff_of(int'(am), md);
    @(negedge clk);
    A = a; amt = am; modo = md; start = 1'b1;
    prev_y = Y;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cyc = 0; got = 1'b0; y_moved = 1'b0;
    while (!got && cyc < 40) begin
      if (Y !== prev_y) y_moved = 1'b1;
      if (scramble) begin
        A = W'($urandom); amt = AW'($urandom); modo = 2'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (busy) busy_cnt++;
      got = done;
    end
    checks++;
    if (!got) begin
      failures++; $display("FAIL %s done_timeout got=0 want=1", nm);
    end
    checks++;
    if (cyc != n + 1) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", nm, cyc, n + 1);
    end
    checks++;
    if (Y !== exp_y) begin
      failures++; $display("FAIL %s result got=%b want=%b", nm, Y, exp_y);
    end
    checks++;
    if (busy_cnt != n + 2) begin
      failures++; $display("FAIL %s busy_cycles got=%0d want=%0d", nm, busy_cnt, n + 2);
    end
    checks++;
    if (y_moved) begin
      failures++; $display("FAIL %s y_changed_while_shifting got=1 want=0", nm);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s after_done done=%b busy=%b want=0/0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (Y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_state Y=%b busy=%b done=%b want=0/0/0", Y, busy, done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(6'b101101, 3'd1, 2'b00, 1'b0, "lsr1");
    run_op(6'b100100, 3'd3, 2'b10, 1'b0, "asr3");
    run_op(6'b010100, 3'd2, 2'b01, 1'b0, "lsl2");
    run_op(6'b000011, 3'd2, 2'b11, 1'b0, "ror2");
    run_op(6'b000011, 3'd7, 2'b11, 1'b0, "ror7");
    run_op(6'b111111, 3'd7, 2'b01, 1'b0, "lsl_clamp");
    run_op(6'b101010, 3'd0, 2'b00, 1'b0, "amt0");
    run_op(6'b100000, 3'd7, 2'b10, 1'b0, "asr_clamp");
    run_op(6'b110011, 3'd6, 2'b00, 1'b0, "lsr6");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), AW'($urandom), 2'($urandom), 1'b1, "random");
  endtask

  task automatic test_ignore_busy();
    int dones;
    @(negedge clk);
    A = 6'b000111; amt = 3'd4; modo = 2'b00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        @(negedge clk); A = 6'b111111; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (done) dones++;
    end
    checks++;
    if (dones != 1) begin
      failures++; $display("FAIL ignore_busy done_pulses got=%0d want=1", dones);
    end
    checks++;
    if (Y !== 6'b000000) begin
      failures++; $display("FAIL ignore_busy result got=%b want=000000", Y);
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    run_op(6'b111000, 3'd1, 2'b01, 1'b0, "pre_reset");
    @(negedge clk);
    A = W'($urandom); amt = 3'd5; modo = 2'b00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL async_reset Y=%b busy=%b done=%b want=0/0/0", Y, busy, done);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++; $display("FAIL reset_no_done activity_cycles got=%0d want=0", dones);
    end
    checks++;
    if (Y !== '0) begin
      failures++; $display("FAIL reset_y_hold got=%b want=000000", Y);
    end
    run_op(6'b100110, 3'd3, 2'b11, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int first, second, n;
    n = eff_of(3, 2'b01);
    @(negedge clk);
    A = 6'b001011; amt = 3'd3; modo = 2'b01; start = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    @(negedge clk); start = 1'b0;
    checks++;
    if (second < 0 || second - first != n + 3) begin
      failures++; $display("FAIL back_to_back period got=%0d want=%0d", second - first, n + 3);
    end
    checks++;
    if (Y !== ref_shift(6'b001011, 3, 2'b01)) begin
      failures++; $display("FAIL back_to_back result got=%b want=%b", Y, ref_shift(6'b001011, 3, 2'b01));
    end
    for (int c = 0; c < 12; c++) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
